// File: rtl/wheel_state_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wheel_pkg
// Description : Shared geometry, types and helpers for the wheel state buffer.
//               Holds the FSM state encoding, node/velocity element and array
//               types, and the log2 helper used to size counters and the
//               centre-of-mass accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package wheel_pkg;

    // Wheel geometry (NUM_NODES must be a power of two, >= 2)
    localparam int NUM_NODES     = 4;
    localparam int POSITION_SIZE = 8;
    localparam int VELOCITY_SIZE = 6;

    // Ceiling log2; exact for the power-of-two node counts used here
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int c_NODE_IDX_W = log2(NUM_NODES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    typedef logic signed [POSITION_SIZE-1:0] pos_t;
    typedef logic signed [VELOCITY_SIZE-1:0] vel_t;

    // Index [0] holds x components, [1] holds y components
    typedef pos_t [1:0][NUM_NODES-1:0] node_arr_t;
    typedef vel_t [1:0][NUM_NODES-1:0] vel_arr_t;

endpackage
`default_nettype wire

// File: rtl/wheel_state_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : wheel_state_buffer_if
// Description : Bundle of the frame-control, streamed-beat and state/status
//               signals between the system side (master) and the wheel state
//               buffer (slave).
//   master drives : frame_tick_in, load_in, load_nodes, node/velocity beats,
//                   result_in
//   slave drives  : begin_out, nodes_out, velocities_out, com_x, com_y,
//                   done_out, busy_out, overrun_out, error_out
// Revision    : 1.0 - initial release
// ============================================================================
interface wheel_state_buffer_if;
    import wheel_pkg::*;

    logic      frame_tick_in;
    logic      load_in;
    node_arr_t load_nodes;
    pos_t      node_in_x;
    pos_t      node_in_y;
    logic      node_in_valid;
    vel_t      velocity_in_x;
    vel_t      velocity_in_y;
    logic      velocity_in_valid;
    logic      result_in;

    logic      begin_out;
    node_arr_t nodes_out;
    vel_arr_t  velocities_out;
    pos_t      com_x;
    pos_t      com_y;
    logic      done_out;
    logic      busy_out;
    logic      overrun_out;
    logic      error_out;

    modport master (
        output frame_tick_in, load_in, load_nodes,
        output node_in_x, node_in_y, node_in_valid,
        output velocity_in_x, velocity_in_y, velocity_in_valid,
        output result_in,
        input  begin_out, nodes_out, velocities_out, com_x, com_y,
        input  done_out, busy_out, overrun_out, error_out
    );

    modport slave (
        input  frame_tick_in, load_in, load_nodes,
        input  node_in_x, node_in_y, node_in_valid,
        input  velocity_in_x, velocity_in_y, velocity_in_valid,
        input  result_in,
        output begin_out, nodes_out, velocities_out, com_x, com_y,
        output done_out, busy_out, overrun_out, error_out
    );

endinterface
`default_nettype wire

// File: rtl/wheel_state_buffer_com.sv
`default_nettype none
// ============================================================================
// Module      : wheel_com
// Description : Combinational centre of mass of a node array. Each coordinate
//               is summed at full precision and divided by NUM_NODES with an
//               arithmetic shift (floor toward -inf, no rounding).
//   i_nodes : node array ([0]=x, [1]=y)
//   o_com_x : mean x coordinate
//   o_com_y : mean y coordinate
// Revision    : 1.0 - initial release
// ============================================================================
module wheel_com
    import wheel_pkg::*;
(
    input  node_arr_t i_nodes,
    output pos_t      o_com_x,
    output pos_t      o_com_y
);

    localparam int c_SUM_W = POSITION_SIZE + c_NODE_IDX_W;

    logic signed [c_SUM_W-1:0] w_sum_x;
    logic signed [c_SUM_W-1:0] w_sum_y;

    always_comb begin
        w_sum_x = '0;
        w_sum_y = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            w_sum_x = w_sum_x + {{c_NODE_IDX_W{i_nodes[0][i][POSITION_SIZE-1]}}, i_nodes[0][i]};
            w_sum_y = w_sum_y + {{c_NODE_IDX_W{i_nodes[1][i][POSITION_SIZE-1]}}, i_nodes[1][i]};
        end
    end

    // Dropping the low log2(NUM_NODES) bits of a two's-complement sum is the
    // arithmetic right shift; the mean always fits back into POSITION_SIZE.
    assign o_com_x = w_sum_x[c_SUM_W-1 -: POSITION_SIZE];
    assign o_com_y = w_sum_y[c_SUM_W-1 -: POSITION_SIZE];

endmodule
`default_nettype wire

// File: rtl/wheel_state_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wheel_state_buffer
// Description : Closes the per-frame physics loop downstream of update_wheel.
//               Issues begin per frame tick, gathers streamed node/velocity
//               beats into a shadow buffer and commits them atomically to the
//               active state when update_wheel reports its result. Provides
//               the centre of mass of the active nodes plus sticky overrun and
//               error status.
//   clk_in  : system clock
//   rst_in  : asynchronous active-high reset
//   bus     : wheel_state_buffer_if.slave (control, beats, state, status)
// Revision    : 1.0 - initial release
// ============================================================================
module wheel_state_buffer
    import wheel_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    wheel_state_buffer_if.slave   bus
);

    localparam int                    c_CNT_W        = c_NODE_IDX_W + 1;
    localparam int                    c_TIMER_W      = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0]    c_FULL         = c_CNT_W'(NUM_NODES);
    localparam logic [c_TIMER_W-1:0]  c_TIMEOUT_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;

    logic [c_CNT_W-1:0]    r_node_cnt;
    logic [c_CNT_W-1:0]    r_vel_cnt;
    logic [c_TIMER_W-1:0]  r_timer;
    node_arr_t             r_shadow_nodes;
    vel_arr_t              r_shadow_vels;

    node_arr_t             r_nodes;
    vel_arr_t              r_vels;
    pos_t                  r_com_x;
    pos_t                  r_com_y;
    logic                  r_begin;
    logic                  r_done;
    logic                  r_overrun;
    logic                  r_error;

    logic                  w_idle;
    logic                  w_run;
    logic                  w_commit;
    logic                  w_load;
    logic                  w_start;
    logic                  w_node_take;
    logic                  w_node_drop;
    logic                  w_vel_take;
    logic                  w_vel_drop;
    logic [c_CNT_W-1:0]    w_node_cnt_nxt;
    logic [c_CNT_W-1:0]    w_vel_cnt_nxt;
    logic                  w_counts_ok;
    logic                  w_result_bad;
    logic                  w_timeout;
    node_arr_t             w_com_src;
    pos_t                  w_com_x;
    pos_t                  w_com_y;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    assign w_idle   = (r_state == ST_IDLE);
    assign w_run    = (r_state == ST_RUN);
    assign w_commit = (r_state == ST_COMMIT);

    // Load wins over a same-cycle tick; that tick is silently dropped
    assign w_load  = w_idle && bus.load_in;
    assign w_start = w_idle && bus.frame_tick_in && !bus.load_in;

    assign w_node_take = w_run && bus.node_in_valid     && (r_node_cnt != c_FULL);
    assign w_node_drop = w_run && bus.node_in_valid     && (r_node_cnt == c_FULL);
    assign w_vel_take  = w_run && bus.velocity_in_valid && (r_vel_cnt  != c_FULL);
    assign w_vel_drop  = w_run && bus.velocity_in_valid && (r_vel_cnt  == c_FULL);

    // A beat arriving together with result_in still counts toward completion
    assign w_node_cnt_nxt = r_node_cnt + {{(c_CNT_W-1){1'b0}}, w_node_take};
    assign w_vel_cnt_nxt  = r_vel_cnt  + {{(c_CNT_W-1){1'b0}}, w_vel_take};
    assign w_counts_ok    = (w_node_cnt_nxt == c_FULL) && (w_vel_cnt_nxt == c_FULL);

    assign w_result_bad = w_run && bus.result_in && !w_counts_ok;
    assign w_timeout    = w_run && !bus.result_in && (r_timer == c_TIMEOUT_LAST);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.result_in) begin
                    w_state_next = w_counts_ok ? ST_COMMIT : ST_IDLE;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Centre of mass, computed on whichever array is about to become active
    // ------------------------------------------------------------------------
    assign w_com_src = w_commit ? r_shadow_nodes : bus.load_nodes;

    wheel_com u_com (
        .i_nodes (w_com_src),
        .o_com_x (w_com_x),
        .o_com_y (w_com_y)
    );

    // ------------------------------------------------------------------------
    // Shadow capture: counters, timer and shadow arrays
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_node_cnt     <= '0;
            r_vel_cnt      <= '0;
            r_timer        <= '0;
            r_shadow_nodes <= '0;
            r_shadow_vels  <= '0;
        end else if (w_start) begin
            r_node_cnt     <= '0;
            r_vel_cnt      <= '0;
            r_timer        <= '0;
            r_shadow_nodes <= '0;
            r_shadow_vels  <= '0;
        end else if (w_run) begin
            r_timer    <= r_timer + 1'b1;
            r_node_cnt <= w_node_cnt_nxt;
            r_vel_cnt  <= w_vel_cnt_nxt;
            if (w_node_take) begin
                r_shadow_nodes[0][r_node_cnt[c_NODE_IDX_W-1:0]] <= bus.node_in_x;
                r_shadow_nodes[1][r_node_cnt[c_NODE_IDX_W-1:0]] <= bus.node_in_y;
            end
            if (w_vel_take) begin
                r_shadow_vels[0][r_vel_cnt[c_NODE_IDX_W-1:0]] <= bus.velocity_in_x;
                r_shadow_vels[1][r_vel_cnt[c_NODE_IDX_W-1:0]] <= bus.velocity_in_y;
            end
            // An incomplete frame is thrown away rather than left half-written
            if (w_result_bad) begin
                r_shadow_nodes <= '0;
                r_shadow_vels  <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Active state, pulses and sticky status
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_nodes   <= '0;
            r_vels    <= '0;
            r_com_x   <= '0;
            r_com_y   <= '0;
            r_begin   <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_begin <= w_start;
            r_done  <= w_load || w_commit;

            if (w_load) begin
                r_nodes <= bus.load_nodes;
                r_vels  <= '0;
                r_com_x <= w_com_x;
                r_com_y <= w_com_y;
            end else if (w_commit) begin
                r_nodes <= r_shadow_nodes;
                r_vels  <= r_shadow_vels;
                r_com_x <= w_com_x;
                r_com_y <= w_com_y;
            end

            if (bus.frame_tick_in && !w_idle) begin
                r_overrun <= 1'b1;
            end
            if (w_node_drop || w_vel_drop || w_result_bad || w_timeout) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.begin_out      = r_begin;
    assign bus.nodes_out      = r_nodes;
    assign bus.velocities_out = r_vels;
    assign bus.com_x          = r_com_x;
    assign bus.com_y          = r_com_y;
    assign bus.done_out       = r_done;
    assign bus.busy_out       = !w_idle;
    assign bus.overrun_out    = r_overrun;
    assign bus.error_out      = r_error;

endmodule
`default_nettype wire
